// File: rtl/boot_req_pkg.sv
// Shared definitions for the reboot-request path: FSM states, image codes, default unlock key.
package boot_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  BOOT_IMAGE       = 2'b01;
  localparam logic [1:0]  USER_IMAGE       = 2'b10;
  localparam logic [15:0] BOOT_KEY_DEFAULT = 16'hB007;

endpackage

// File: rtl/boot_req_presc.sv
// Free-running TICK_W-bit tick prescaler with synchronous clear; o_wrap pulses for one
// cycle on the last count before wrap. No backpressure.
module boot_req_presc #(
  parameter int TICK_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_wrap
);

  logic [TICK_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_wrap = i_en & ~i_clr & (r_cnt == {TICK_W{1'b1}});

endmodule

// File: rtl/boot_req_ctrl.sv
// Reboot request -> delayed boot_sel/boot_now strobe; abortable while waiting, terminal after firing.
// Requests stall outside IDLE; optional key check under `BOOT_REQ_KEY_EN.
module boot_req_ctrl
  import boot_req_pkg::*;
#(
  parameter int          DLY_W  = 8,
  parameter int          TICK_W = 16,
  parameter logic [15:0] KEY    = BOOT_KEY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_sel,
  input  logic [DLY_W-1:0] req_delay,
  input  logic [15:0]      req_key,
  output logic             req_err,
  input  logic             abort,
  output logic             busy,
  output logic [DLY_W-1:0] cnt_rem,
  output logic [1:0]       boot_sel,
  output logic             boot_now
);

  state_t           r_state, w_state_nxt;
  logic [DLY_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_boot_sel, w_sel_nxt;
  logic             w_hs;
  logic             w_key_ok;
  logic             w_wrap;

  assign req_ready = (r_state == ST_IDLE) & ~abort;
  assign w_hs      = req_valid & req_ready;

`ifdef BOOT_REQ_KEY_EN
  logic r_req_err;

  assign w_key_ok = (req_key == KEY);

  // A bad key still completes the handshake; only the error pulse records it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_err <= 1'b0;
    end else begin
      r_req_err <= w_hs & ~w_key_ok;
    end
  end

  assign req_err = r_req_err;
`else
  logic w_unused;

  assign w_key_ok = 1'b1;
  assign w_unused = ^{req_key, KEY};
  assign req_err  = 1'b0;
`endif

  boot_req_presc #(.TICK_W(TICK_W)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (r_state != ST_WAIT),
    .i_en   (r_state == ST_WAIT),
    .o_wrap (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_boot_sel <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_boot_sel <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_boot_sel;
    case (r_state)
      ST_IDLE: begin
        if (w_hs && w_key_ok) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = req_delay;
          w_sel_nxt   = req_sel;
        end
      end
      ST_WAIT: begin
        // Abort outranks both the fire decision and the tick decrement.
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_FIRE;
        end else if (w_wrap) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_FIRE: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (r_state != ST_IDLE);
  assign boot_now = (r_state == ST_FIRE);
  assign boot_sel = r_boot_sel;
  assign cnt_rem  = (r_state == ST_WAIT) ? r_cnt : '0;

endmodule

// File: tb/tb_boot_req_ctrl.sv
// Randomised bench for boot_req_ctrl: timing model predicts fire cycles, a monitor checks outputs.
module tb_boot_req_ctrl;
  import boot_req_pkg::*;

  localparam int DLY_W  = 8;
  localparam int TICK_W = 4;
  localparam int TPER   = 1 << TICK_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_sel = 2'b00;
  logic [DLY_W-1:0] req_delay = '0;
  logic [15:0]      req_key = 16'hB007;
  logic             req_err;
  logic             abort = 1'b0;
  logic             busy;
  logic [DLY_W-1:0] cnt_rem;
  logic [1:0]       boot_sel;
  logic             boot_now;

  always #5 clk = ~clk;

  boot_req_ctrl #(.DLY_W(DLY_W), .TICK_W(TICK_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_delay(req_delay), .req_key(req_key), .req_err(req_err),
    .abort(abort), .busy(busy), .cnt_rem(cnt_rem), .boot_sel(boot_sel), .boot_now(boot_now)
  );

  typedef struct {
    int         cyc;
    logic [1:0] sel;
  } fire_t;

  fire_t      exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_fire = 0;
  int         cyc = 0;
  // Model: phase 0 = idle, 1 = request pending, 2 = fired (terminal)
  int         m_phase = 0;
  int         m_e0 = 0;
  int         m_n = 0;
  int         m_fire = 0;
  int         m_err_cyc = -10;
  logic [1:0] m_sel = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit key_ok(input logic [15:0] k);
`ifdef BOOT_REQ_KEY_EN
    return k == 16'hB007;
`else
    return (k == k);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input int d, input logic [15:0] k);
    req_valid = 1'b1;
    req_sel   = s;
    req_delay = DLY_W'(d);
    req_key   = k;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic reset_checks();
    check("rst_boot_now", boot_now, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt_rem", cnt_rem, 0);
    check("rst_boot_sel", boot_sel, 0);
    check("rst_req_err", req_err, 0);
    check("rst_req_ready", req_ready, !abort);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    reset_checks();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reference: a request accepted at edge E with delay N fires on edge E + N*TPER + 1.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase   = 0;
        m_sel     = 2'b00;
        m_err_cyc = -10;
        exp_q.delete();
      end else begin
        cyc = cyc + 1;
        if (m_phase == 0) begin
          if (req_valid && !abort) begin
            if (key_ok(req_key)) begin
              m_phase = 1;
              m_e0    = cyc;
              m_n     = int'(req_delay);
              m_sel   = req_sel;
              m_fire  = cyc + m_n * TPER + 1;
              exp_q.push_back('{m_fire, req_sel});
            end else begin
              m_err_cyc = cyc;
            end
          end
        end else if (m_phase == 1) begin
          if (abort) begin
            m_phase = 0;
            void'(exp_q.pop_back());
          end else if (cyc == m_fire) begin
            m_phase = 2;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bit exp_now;
        int exp_cnt;
        exp_cnt = (m_phase == 1) ? (m_n - (cyc - m_e0) / TPER) : 0;
        exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("req_ready", req_ready, (m_phase == 0) && !abort);
        check("busy", busy, m_phase != 0);
        check("cnt_rem", cnt_rem, exp_cnt);
        check("boot_sel", boot_sel, m_sel);
        check("req_err", req_err, m_err_cyc == cyc);
        check("boot_now", boot_now, exp_now);
        if (boot_now && exp_now) begin
          check("fire_sel", boot_sel, exp_q[0].sel);
          n_fire++;
        end
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int d;
    rst_n = 1'b0;
    #1;
    reset_checks();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Zero delay, then requests/aborts held against the terminal state
    send(BOOT_IMAGE, 0, 16'hB007);
    repeat (4) tick();
    req_valid = 1'b1;
    abort     = 1'b1;
    repeat (4) tick();
    req_valid = 1'b0;
    abort     = 1'b0;
    tick();
    do_reset();

    // Three-tick delay
    send(USER_IMAGE, 3, 16'hB007);
    repeat (3 * TPER + 6) tick();
    do_reset();

    // Abort after two ticks, then a fresh request
    send(2'b11, 5, 16'hB007);
    repeat (2 * TPER + 3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    send(BOOT_IMAGE, 1, 16'hB007);
    repeat (TPER + 5) tick();
    do_reset();

    // Request with abort in IDLE is refused; request held through WAIT; reset mid-WAIT
    req_valid = 1'b1;
    req_sel   = BOOT_IMAGE;
    req_delay = 8'd2;
    abort     = 1'b1;
    tick();
    abort = 1'b0;
    repeat (10) tick();
    req_valid = 1'b0;
    do_reset();

    // Abort landing on the same edge the delay expires
    send(USER_IMAGE, 1, 16'hB007);
    repeat (TPER) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    do_reset();

    // Bad key then good key (bad key is ignored without the key feature)
    send(BOOT_IMAGE, 0, 16'h1234);
    repeat (3) tick();
    send(USER_IMAGE, 0, 16'hB007);
    repeat (4) tick();
    do_reset();

    for (int it = 0; it < 25; it++) begin
      d = $urandom_range(0, 4);
      send(2'($urandom_range(0, 3)), d, ($urandom_range(0, 3) == 0) ? 16'h1234 : 16'hB007);
      for (int c = 0; c < d * TPER + 6; c++) begin
        abort     = ($urandom_range(0, 39) == 0);
        req_valid = ($urandom_range(0, 3) == 0);
        req_sel   = 2'($urandom_range(0, 3));
        req_delay = DLY_W'($urandom_range(0, 2));
        tick();
      end
      abort     = 1'b0;
      req_valid = 1'b0;
      do_reset();
    end

    // Maximum delay
    send(USER_IMAGE, 255, 16'hB007);
    repeat (255 * TPER + 6) tick();

    check("queue_drained", exp_q.size(), 0);
    check("fires_seen_nonzero", n_fire > 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
